// File: rtl/irq_source_ctrl.sv
// irq_source_ctrl
//
// Interrupt source controller feeding the core's interrupt control stage.
// Peripheral lines are synchronised, latched per source as edge- or
// level-triggered pending bits, masked by a software enable register and
// presented as a registered flag vector. One source index is owned by an
// internal 64-bit machine timer compare instead of its peripheral line.
//
// Ports:
//   clk         clock
//   rst_n       asynchronous active-low reset
//   irq_i       raw peripheral interrupt lines (may be asynchronous)
//   req_i       bus access request, one cycle per access
//   we_i        1 = write, 0 = read (qualified by req_i)
//   addr_i      byte address, bits [1:0] ignored
//   wdata_i     write data
//   rdata_o     read data, valid while ack_o = 1, else 0
//   ack_o       access complete, one cycle after req_i
//   int_flag_o  registered pending & enable, drives the core's int_flag_i
//
// Register map (word index = addr_i[7:2]):
//   0x00 PENDING (W1C, edge sources only)   0x04 ENABLE   0x08 MODE (1 = edge)
//   0x10 MTIME_LO   0x14 MTIME_HI   0x18 MTIMECMP_LO   0x1C MTIMECMP_HI
//   anything else reads 0, ignores writes, still acks.
module irq_source_ctrl #(
  parameter int INT_W     = 14,
  parameter int TIMER_SRC = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [INT_W-1:0] irq_i,
  input  logic             req_i,
  input  logic             we_i,
  input  logic [7:0]       addr_i,
  input  logic [31:0]      wdata_i,
  output logic [31:0]      rdata_o,
  output logic             ack_o,
  output logic [INT_W-1:0] int_flag_o
);

  // Word indices of the mapped registers.
  localparam logic [5:0] A_PENDING   = 6'h00;
  localparam logic [5:0] A_ENABLE    = 6'h01;
  localparam logic [5:0] A_MODE      = 6'h02;
  localparam logic [5:0] A_MTIME_LO  = 6'h04;
  localparam logic [5:0] A_MTIME_HI  = 6'h05;
  localparam logic [5:0] A_MTCMP_LO  = 6'h06;
  localparam logic [5:0] A_MTCMP_HI  = 6'h07;

  // The timer source is always level mode, so its MODE bit is kept at 0.
  localparam logic [INT_W-1:0] TIMER_MASK = INT_W'(1) << TIMER_SRC;

  // Bus handshake: no back-pressure. Every cycle with req_i = 1 is one
  // access; ack_o is high exactly in the following cycle, with rdata_o
  // holding the pre-write register value for reads and 0 for writes.
  // rdata_o is 0 whenever ack_o is 0.

  logic [5:0]       word;
  logic             wr;
  logic             rd;
  logic             unused_addr;

  logic [INT_W-1:0] s1;
  logic [INT_W-1:0] s2;
  logic [INT_W-1:0] s3;
  logic [INT_W-1:0] rise;

  logic [INT_W-1:0] pending;
  logic [INT_W-1:0] pending_next;
  logic [INT_W-1:0] enable;
  logic [INT_W-1:0] mode;
  logic [INT_W-1:0] w1c;

  logic [63:0]      mtime;
  logic [63:0]      mtimecmp;
  logic             timer_hit;

  logic [31:0]      rd_data;

  assign word        = addr_i[7:2];
  assign wr          = req_i & we_i;
  assign rd          = req_i & ~we_i;
  assign unused_addr = ^addr_i[1:0];

  assign rise      = s2 & ~s3;
  assign timer_hit = (mtime >= mtimecmp);
  assign w1c       = (wr && (word == A_PENDING)) ? wdata_i[INT_W-1:0] : '0;

  // Edge sources: a detected rise sets, else a W1C clears, else hold; a set
  // beats a simultaneous clear. Level sources follow the synchronised line.
  always_comb begin
    pending_next            = (mode & (rise | (pending & ~w1c))) | (~mode & s2);
    pending_next[TIMER_SRC] = timer_hit;
  end

  // Read mux, sampled before any write in the same cycle takes effect.
  always_comb begin
    rd_data = '0;
    case (word)
      A_PENDING:  rd_data = {{(32-INT_W){1'b0}}, pending};
      A_ENABLE:   rd_data = {{(32-INT_W){1'b0}}, enable};
      A_MODE:     rd_data = {{(32-INT_W){1'b0}}, mode};
      A_MTIME_LO: rd_data = mtime[31:0];
      A_MTIME_HI: rd_data = mtime[63:32];
      A_MTCMP_LO: rd_data = mtimecmp[31:0];
      A_MTCMP_HI: rd_data = mtimecmp[63:32];
      default:    rd_data = '0;
    endcase
  end

  // Synchroniser and edge-detect delay flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
    end else begin
      s1 <= irq_i;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // Pending, configuration and output flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending    <= '0;
      enable     <= '0;
      mode       <= '0;
      int_flag_o <= '0;
    end else begin
      pending    <= pending_next;
      int_flag_o <= pending & enable;
      if (wr && (word == A_ENABLE)) begin
        enable <= wdata_i[INT_W-1:0];
      end
      if (wr && (word == A_MODE)) begin
        mode <= wdata_i[INT_W-1:0] & ~TIMER_MASK;
      end
    end
  end

  // Machine timer. A write to either half replaces that half and freezes
  // the counter for that cycle, so the other half is not disturbed by a
  // carry mid-update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mtime    <= '0;
      mtimecmp <= '1;
    end else begin
      if (wr && (word == A_MTIME_LO)) begin
        mtime[31:0] <= wdata_i;
      end else if (wr && (word == A_MTIME_HI)) begin
        mtime[63:32] <= wdata_i;
      end else begin
        mtime <= mtime + 64'd1;
      end
      if (wr && (word == A_MTCMP_LO)) begin
        mtimecmp[31:0] <= wdata_i;
      end
      if (wr && (word == A_MTCMP_HI)) begin
        mtimecmp[63:32] <= wdata_i;
      end
    end
  end

  // Bus response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_o   <= 1'b0;
      rdata_o <= '0;
    end else begin
      ack_o   <= req_i;
      rdata_o <= rd ? rd_data : 32'd0;
    end
  end

endmodule

// File: tb/tb_irq_source_ctrl.sv
// tb_irq_source_ctrl
//
// Directed self-checking bench for irq_source_ctrl. Inputs change on the
// falling clock edge; outputs are sampled on the falling edge, half a
// period after the rising edge that updated them.
module tb_irq_source_ctrl;

  localparam int INT_W = 14;

  localparam logic [7:0] R_PENDING  = 8'h00;
  localparam logic [7:0] R_ENABLE   = 8'h04;
  localparam logic [7:0] R_MODE     = 8'h08;
  localparam logic [7:0] R_MTIME_LO = 8'h10;
  localparam logic [7:0] R_MTIME_HI = 8'h14;
  localparam logic [7:0] R_CMP_LO   = 8'h18;
  localparam logic [7:0] R_CMP_HI   = 8'h1C;

  logic             clk;
  logic             rst_n;
  logic [INT_W-1:0] irq;
  logic             req;
  logic             we;
  logic [7:0]       addr;
  logic [31:0]      wdata;
  logic [31:0]      rdata;
  logic             ack;
  logic [INT_W-1:0] int_flag;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [31:0] last_rdata;
  logic        last_ack;

  irq_source_ctrl #(.INT_W(INT_W), .TIMER_SRC(7)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .irq_i      (irq),
    .req_i      (req),
    .we_i       (we),
    .addr_i     (addr),
    .wdata_i    (wdata),
    .rdata_o    (rdata),
    .ack_o      (ack),
    .int_flag_o (int_flag)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
    $fatal(1);
  end

  // ---------------- driver tasks ----------------
  // All tasks are entered at a falling edge and return at a falling edge.
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_write(input logic [7:0] a, input logic [31:0] d);
    req = 1'b1; we = 1'b1; addr = a; wdata = d;
    @(negedge clk);
    last_ack = ack; last_rdata = rdata;
    req = 1'b0; we = 1'b0;
  endtask

  task automatic bus_read(input logic [7:0] a, output logic [31:0] d);
    req = 1'b1; we = 1'b0; addr = a; wdata = '0;
    @(negedge clk);
    d = rdata; last_ack = ack; last_rdata = rdata;
    req = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [31:0] d;
    rst_n = 1'b0; irq = '0; req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    tick(3);
    tests_run++;
    if (int_flag !== 14'h0 || ack !== 1'b0 || rdata !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got flag=%h ack=%b rdata=%h, want 0/0/0", int_flag, ack, rdata);
    end
    rst_n = 1'b1;
    tick(1);
    bus_read(R_PENDING, d);
    tests_run++;
    if (d !== 32'h0 || last_ack !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_pending: got %h ack=%b, want 00000000 ack=1", d, last_ack);
    end
    bus_read(R_ENABLE, d);
    tests_run++;
    if (d !== 32'h0) begin tests_failed++; $display("FAIL reset_enable: got %h, want 00000000", d); end
    bus_read(R_MODE, d);
    tests_run++;
    if (d !== 32'h0) begin tests_failed++; $display("FAIL reset_mode: got %h, want 00000000", d); end
    bus_read(R_CMP_LO, d);
    tests_run++;
    if (d !== 32'hFFFF_FFFF) begin tests_failed++; $display("FAIL reset_cmp_lo: got %h, want ffffffff", d); end
    bus_read(R_CMP_HI, d);
    tests_run++;
    if (d !== 32'hFFFF_FFFF) begin tests_failed++; $display("FAIL reset_cmp_hi: got %h, want ffffffff", d); end
    bus_read(R_MTIME_HI, d);
    tests_run++;
    if (d !== 32'h0) begin tests_failed++; $display("FAIL reset_mtime_hi: got %h, want 00000000", d); end
    tick(1);
    tests_run++;
    if (ack !== 1'b0 || rdata !== 32'h0 || int_flag !== 14'h0) begin
      tests_failed++;
      $display("FAIL reset_idle: got ack=%b rdata=%h flag=%h, want 0/0/0", ack, rdata, int_flag);
    end
  endtask

  task automatic test_regs();
    logic [31:0] d;
    bus_write(R_MODE, 32'hFFFF_FFFF);
    tests_run++;
    if (last_ack !== 1'b1 || last_rdata !== 32'h0) begin
      tests_failed++;
      $display("FAIL write_response: got ack=%b rdata=%h, want ack=1 rdata=0", last_ack, last_rdata);
    end
    bus_read(R_MODE, d);
    tests_run++;
    if (d !== 32'h0000_3F7F) begin tests_failed++; $display("FAIL mode_mask: got %h, want 00003f7f", d); end
    bus_write(R_ENABLE, 32'hFFFF_FFFF);
    bus_read(R_ENABLE, d);
    tests_run++;
    if (d !== 32'h0000_3FFF) begin tests_failed++; $display("FAIL enable_mask: got %h, want 00003fff", d); end
    bus_write(8'h0C, 32'hFFFF_FFFF);
    bus_read(8'h0C, d);
    tests_run++;
    if (d !== 32'h0 || last_ack !== 1'b1) begin
      tests_failed++;
      $display("FAIL unmapped_read: got %h ack=%b, want 00000000 ack=1", d, last_ack);
    end
    bus_write(R_MODE, 32'h0);
    bus_write(R_ENABLE, 32'h0);
  endtask

  task automatic test_edge();
    logic [31:0] d;
    bus_write(R_MODE, 32'h1);
    bus_write(R_ENABLE, 32'h1);
    irq[0] = 1'b1;
    tick(3);                    // after N+2
    irq[0] = 1'b0;
    tests_run++;
    if (int_flag !== 14'h0000) begin tests_failed++; $display("FAIL edge_early: got %h, want 0000", int_flag); end
    tick(1);                    // after N+3
    tests_run++;
    if (int_flag !== 14'h0001) begin tests_failed++; $display("FAIL edge_flag: got %h, want 0001", int_flag); end
    tick(4);
    tests_run++;
    if (int_flag !== 14'h0001) begin tests_failed++; $display("FAIL edge_hold: got %h, want 0001", int_flag); end
    bus_read(R_PENDING, d);
    tests_run++;
    if (d !== 32'h1) begin tests_failed++; $display("FAIL edge_pending: got %h, want 00000001", d); end
    bus_write(R_PENDING, 32'h1);
    tests_run++;
    if (int_flag !== 14'h0001) begin tests_failed++; $display("FAIL w1c_same_cycle: got %h, want 0001", int_flag); end
    tick(1);
    tests_run++;
    if (int_flag !== 14'h0000) begin tests_failed++; $display("FAIL w1c_clear: got %h, want 0000", int_flag); end
  endtask

  task automatic test_level_mask();
    logic [31:0] d;
    bus_write(R_ENABLE, 32'h0);
    irq[3] = 1'b1;
    tick(4);
    bus_read(R_PENDING, d);
    tests_run++;
    if (d !== 32'h8 || int_flag !== 14'h0) begin
      tests_failed++;
      $display("FAIL level_masked: got pending=%h flag=%h, want 00000008/0000", d, int_flag);
    end
    bus_write(R_ENABLE, 32'h8);
    tick(1);
    tests_run++;
    if (int_flag !== 14'h0008) begin tests_failed++; $display("FAIL level_enable: got %h, want 0008", int_flag); end
    bus_write(R_PENDING, 32'h8);
    bus_read(R_PENDING, d);
    tests_run++;
    if (d !== 32'h8 || int_flag !== 14'h0008) begin
      tests_failed++;
      $display("FAIL level_w1c: got pending=%h flag=%h, want 00000008/0008", d, int_flag);
    end
    irq[3] = 1'b0;
    tick(3);                    // after N+2
    tests_run++;
    if (int_flag !== 14'h0008) begin tests_failed++; $display("FAIL level_fall_early: got %h, want 0008", int_flag); end
    tick(1);                    // after N+3
    tests_run++;
    if (int_flag !== 14'h0000) begin tests_failed++; $display("FAIL level_fall: got %h, want 0000", int_flag); end
  endtask

  task automatic test_collision();
    logic [31:0] d;
    bus_write(R_MODE, 32'h21);
    bus_write(R_ENABLE, 32'h20);
    irq[5] = 1'b1;
    tick(3);
    irq[5] = 1'b0;
    tick(4);
    bus_read(R_PENDING, d);
    tests_run++;
    if (d !== 32'h20) begin tests_failed++; $display("FAIL collide_setup: got %h, want 00000020", d); end
    irq[5] = 1'b1;
    tick(2);                    // after N+1: rise is seen at edge N+2
    bus_write(R_PENDING, 32'h20);
    bus_read(R_PENDING, d);
    tests_run++;
    if (d !== 32'h20) begin tests_failed++; $display("FAIL collide_set_wins: got %h, want 00000020", d); end
    bus_write(R_PENDING, 32'h20);
    bus_read(R_PENDING, d);
    tests_run++;
    if (d !== 32'h0) begin tests_failed++; $display("FAIL collide_later_clear: got %h, want 00000000", d); end
    irq[5] = 1'b0;
    tick(3);
  endtask

  task automatic test_timer();
    logic [31:0] d;
    bus_write(R_ENABLE, 32'h80);
    bus_write(R_CMP_HI, 32'h1);
    bus_write(R_CMP_LO, 32'h0);
    bus_write(R_MTIME_HI, 32'h0);
    bus_write(R_MTIME_LO, 32'hFFFF_FFF0);     // edge W, now k=0
    bus_read(R_MTIME_LO, d);                  // k=1
    tests_run++;
    if (d !== 32'hFFFF_FFF0) begin tests_failed++; $display("FAIL mtime_lo_write: got %h, want fffffff0", d); end
    bus_read(R_MTIME_HI, d);                  // k=2
    tests_run++;
    if (d !== 32'h0 || int_flag !== 14'h0) begin
      tests_failed++;
      $display("FAIL mtime_hi_before: got hi=%h flag=%h, want 00000000/0000", d, int_flag);
    end
    tick(14);                                 // k=16
    bus_read(R_MTIME_HI, d);                  // k=17, value after W+16
    tests_run++;
    if (d !== 32'h1) begin tests_failed++; $display("FAIL mtime_carry: got %h, want 00000001", d); end
    tests_run++;
    if (int_flag !== 14'h0) begin tests_failed++; $display("FAIL timer_early: got %h, want 0000", int_flag); end
    tick(1);                                  // k=18
    tests_run++;
    if (int_flag !== 14'h0080) begin tests_failed++; $display("FAIL timer_flag: got %h, want 0080", int_flag); end
    bus_write(R_CMP_HI, 32'hFFFF_FFFF);
    tick(2);
    tests_run++;
    if (int_flag !== 14'h0000) begin tests_failed++; $display("FAIL timer_clear: got %h, want 0000", int_flag); end
  endtask

  task automatic test_async_reset();
    logic [31:0] d;
    bus_write(R_MODE, 32'h3FFF);
    bus_write(R_ENABLE, 32'h3FFF);
    bus_write(R_CMP_HI, 32'h0);
    bus_write(R_CMP_LO, 32'h0);
    irq = '1;
    tick(3);
    irq = '0;
    tick(4);
    bus_read(R_PENDING, d);
    tests_run++;
    if (d !== 32'h3FFF || int_flag !== 14'h3FFF) begin
      tests_failed++;
      $display("FAIL all_pending: got pending=%h flag=%h, want 00003fff/3fff", d, int_flag);
    end
    req = 1'b1; we = 1'b0; addr = R_PENDING;
    @(posedge clk);
    #1;
    tests_run++;
    if (ack !== 1'b1 || rdata !== 32'h3FFF) begin
      tests_failed++;
      $display("FAIL inflight_ack: got ack=%b rdata=%h, want 1/00003fff", ack, rdata);
    end
    rst_n = 1'b0;
    req = 1'b0;
    #1;
    tests_run++;
    if (ack !== 1'b0 || rdata !== 32'h0 || int_flag !== 14'h0) begin
      tests_failed++;
      $display("FAIL async_reset: got ack=%b rdata=%h flag=%h, want 0/0/0", ack, rdata, int_flag);
    end
    tick(2);
    rst_n = 1'b1;
    tick(1);
    bus_read(R_CMP_LO, d);
    tests_run++;
    if (d !== 32'hFFFF_FFFF) begin tests_failed++; $display("FAIL rst_cmp_lo: got %h, want ffffffff", d); end
    bus_read(R_CMP_HI, d);
    tests_run++;
    if (d !== 32'hFFFF_FFFF) begin tests_failed++; $display("FAIL rst_cmp_hi: got %h, want ffffffff", d); end
    bus_read(R_PENDING, d);
    tests_run++;
    if (d !== 32'h0) begin tests_failed++; $display("FAIL rst_pending: got %h, want 00000000", d); end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    last_rdata = '0;
    last_ack   = 1'b0;
    test_reset();
    test_regs();
    test_edge();
    test_level_mask();
    test_collision();
    test_timer();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
